regfile_wr_arbiter: RTL

//  Shares the single register-file write port (we3/A3/WD3 of memory_reg) between two writeback sources:

---
 rtl/mips_pkg.sv | 13 +
 rtl/rr_arb2.sv | 44 ++++
 rtl/regfile_wr_arbiter.sv | 116 +++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared widths and the register-file write record used by the writeback path.
package mips_pkg;

    localparam int unsigned REG_AW = 5;
    localparam int unsigned DATA_W = 32;
    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [REG_AW-1:0] addr;
        logic [DATA_W-1:0] data;
    } rf_wr_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; when both requests target the same register the older
// entry wins so writes to one register land in transfer order.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] valid,
    input  logic       same_addr,
    input  logic       older,
    output logic [1:0] grant
);

    // last_q: index of the most recently granted port; reset to 1 so port 0 wins first
    logic last_q;
    logic last_d;

    always_comb begin
        grant  = 2'b00;
        last_d = last_q;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11: begin
                if (same_addr) begin
                    grant = older ? 2'b10 : 2'b01;
                end else begin
                    grant = last_q ? 2'b01 : 2'b10;
                end
            end
            default: grant = 2'b00;
        endcase
        if (grant != 2'b00) begin
            last_d = grant[1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Shares the register-file write port between the pipeline writeback (port 0) and the
// multi-cycle unit (port 1) through one-entry hold buffers and a registered write stage.
module regfile_wr_arbiter
    import mips_pkg::*;
#(
    parameter int unsigned AW = REG_AW,
    parameter int unsigned DW = DATA_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [AW-1:0]        req0_addr,
    input  logic [DW-1:0]        req0_data,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [AW-1:0]        req1_addr,
    input  logic [DW-1:0]        req1_data,
    output logic                 rf_we3,
    output logic [AW-1:0]        rf_A3,
    output logic [DW-1:0]        rf_WD3,
    output logic [(1<<AW)-1:0]   pend_mask
);

    logic          hold0_v_q, hold1_v_q;
    logic [AW-1:0] hold0_addr_q, hold1_addr_q;
    logic [DW-1:0] hold0_data_q, hold1_data_q;
    // age_q=1: hold 1 holds the older entry
    logic          age_q, age_d;

    logic [1:0]    grant;
    logic          load0, load1, keep0, keep1;

    rr_arb2 u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid     ({hold1_v_q, hold0_v_q}),
        .same_addr (hold0_addr_q == hold1_addr_q),
        .older     (age_q),
        .grant     (grant)
    );

    assign req0_ready = !hold0_v_q | grant[0];
    assign req1_ready = !hold1_v_q | grant[1];

    // Writes to register 0 are handshaken but dropped here
    assign load0 = req0_valid & req0_ready & (req0_addr != '0);
    assign load1 = req1_valid & req1_ready & (req1_addr != '0);
    assign keep0 = hold0_v_q & ~grant[0];
    assign keep1 = hold1_v_q & ~grant[1];

    always_comb begin
        age_d = age_q;
        if (load0 && load1) begin
            age_d = 1'b0;
        end else if (load0 && keep1) begin
            age_d = 1'b1;
        end else if (load1 && keep0) begin
            age_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold0_v_q    <= 1'b0;
            hold1_v_q    <= 1'b0;
            hold0_addr_q <= '0;
            hold1_addr_q <= '0;
            hold0_data_q <= '0;
            hold1_data_q <= '0;
            age_q        <= 1'b0;
            rf_we3       <= 1'b0;
            rf_A3        <= '0;
            rf_WD3       <= '0;
        end else begin
            if (load0) begin
                hold0_v_q    <= 1'b1;
                hold0_addr_q <= req0_addr;
                hold0_data_q <= req0_data;
            end else if (grant[0]) begin
                hold0_v_q <= 1'b0;
            end
            if (load1) begin
                hold1_v_q    <= 1'b1;
                hold1_addr_q <= req1_addr;
                hold1_data_q <= req1_data;
            end else if (grant[1]) begin
                hold1_v_q <= 1'b0;
            end
            age_q  <= age_d;
            rf_we3 <= |grant;
            if (grant[0]) begin
                rf_A3  <= hold0_addr_q;
                rf_WD3 <= hold0_data_q;
            end else if (grant[1]) begin
                rf_A3  <= hold1_addr_q;
                rf_WD3 <= hold1_data_q;
            end
        end
    end

    always_comb begin
        pend_mask = '0;
        if (hold0_v_q) begin
            pend_mask[hold0_addr_q] = 1'b1;
        end
        if (hold1_v_q) begin
            pend_mask[hold1_addr_q] = 1'b1;
        end
        if (rf_we3) begin
            pend_mask[rf_A3] = 1'b1;
        end
        pend_mask[0] = 1'b0;
    end

endmodule
